// File: rtl/cxl_crd_pkg.sv
// ---------------------------------------------------------------------------
// cxl_crd_pkg
// Shared definitions for the CXL link-layer credit path. The default widths
// and the initial credit pool live here so the receiver-side return
// generator and the transmitter-side credit counter always agree.
//   crd_rtn_state_e : return-generator FSM state (IDLE / INIT / RUN)
//   DEF_CRD_WIDTH   : pending-credit accumulator width
//   DEF_RTN_WIDTH   : width of one credit-return field
//   DEF_INIT_CRD    : credits advertised after link-up
// ---------------------------------------------------------------------------
package cxl_crd_pkg;

   localparam int DEF_CRD_WIDTH = 7;
   localparam int DEF_RTN_WIDTH = 4;
   localparam int DEF_INIT_CRD  = 64;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      INIT = 2'b01,
      RUN  = 2'b10
   } crd_rtn_state_e;

endpackage

// File: rtl/cxl_crd_rtn_timer.sv
// ---------------------------------------------------------------------------
// cxl_crd_rtn_timer
// Saturating idle timer. Counts up while enabled and stops at RTN_TIMEOUT;
// a clear wins over enable.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear to zero
//   i_en           : count enable
//   o_tc           : terminal count reached (count == RTN_TIMEOUT)
// ---------------------------------------------------------------------------
module cxl_crd_rtn_timer #(
   parameter int RTN_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int TW = $clog2(RTN_TIMEOUT + 1);
   localparam logic [TW-1:0] TC_VAL = TW'(RTN_TIMEOUT);

   logic [TW-1:0] count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else if (i_clr) begin
         count <= '0;
      end else if (i_en && (count != TC_VAL)) begin
         count <= count + TW'(1);
      end
   end

   assign o_tc = (count == TC_VAL);

endmodule

// File: rtl/cxl_crd_rtn_gen.sv
// ---------------------------------------------------------------------------
// cxl_crd_rtn_gen
// Receiver-side credit return generator. Accumulates RX entries freed by the
// consumer and hands them back to the remote transmitter as bounded
// credit-return values. After link-up the initial pool INIT_CRD is
// advertised through the same return path before normal operation (RUN).
//
// Return handshake: o_rtn_valid/o_rtn_val form a valid/ready source. Once
// o_rtn_valid is high, o_rtn_val is held stable until i_rtn_ready is seen
// high on a rising edge (the handshake); valid never depends on ready. A
// link-down drops an offer without a handshake.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_link_up      : link trained; low aborts to IDLE
//   i_free_en      : i_free_val valid this cycle
//   i_free_val     : entries freed this cycle
//   i_rtn_ready    : flit packer accepts the offered return
//   o_rtn_valid    : credit return offered
//   o_rtn_val      : credits in the offered return
//   o_pending      : registered pending-credit count
//   o_state        : FSM state (debug)
//   o_err          : sticky accumulator overflow
// ---------------------------------------------------------------------------
module cxl_crd_rtn_gen
   import cxl_crd_pkg::*;
#(
   parameter int CRD_WIDTH   = DEF_CRD_WIDTH,
   parameter int RTN_WIDTH   = DEF_RTN_WIDTH,
   parameter int INIT_CRD    = DEF_INIT_CRD,
   parameter int RTN_THRESH  = 8,
   parameter int RTN_TIMEOUT = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_link_up,
   input  logic                 i_free_en,
   input  logic [CRD_WIDTH-1:0] i_free_val,
   input  logic                 i_rtn_ready,
   output logic                 o_rtn_valid,
   output logic [RTN_WIDTH-1:0] o_rtn_val,
   output logic [CRD_WIDTH-1:0] o_pending,
   output logic [1:0]           o_state,
   output logic                 o_err
);

   localparam int XW      = CRD_WIDTH + 1;
   localparam int RTN_MAX = (1 << RTN_WIDTH) - 1;
   localparam logic [XW-1:0] CRD_LIMIT = {1'b0, {CRD_WIDTH{1'b1}}};

   crd_rtn_state_e       state;
   logic [CRD_WIDTH-1:0] pending;
   logic                 rtn_valid;
   logic [RTN_WIDTH-1:0] rtn_val;
   logic                 err;

   logic                 handshake;
   logic [XW-1:0]        base_ext;
   logic [XW-1:0]        free_ext;
   logic [XW-1:0]        sub_ext;
   logic [XW-1:0]        next_ext;
   logic                 overflow;
   logic [CRD_WIDTH-1:0] next_pending;
   logic [RTN_WIDTH-1:0] rtn_clamp;
   logic                 issue;
   logic                 timer_clr;
   logic                 timer_tc;

   assign handshake = rtn_valid & i_rtn_ready;

   // Next pending count, one bit wider so overflow is visible. Leaving IDLE
   // the base is the initial pool rather than the (zero) register.
   always_comb begin
      base_ext     = (state == IDLE) ? XW'(INIT_CRD) : {1'b0, pending};
      free_ext     = i_free_en ? {1'b0, i_free_val} : '0;
      sub_ext      = handshake ? XW'(rtn_val) : '0;
      next_ext     = base_ext + free_ext - sub_ext;
      overflow     = (next_ext > CRD_LIMIT);
      next_pending = overflow ? '1 : next_ext[CRD_WIDTH-1:0];
   end

   assign rtn_clamp = (pending > CRD_WIDTH'(RTN_MAX)) ? RTN_WIDTH'(RTN_MAX)
                                                      : pending[RTN_WIDTH-1:0];

   // Issue decisions use registered state only, so valid rises one cycle
   // after the condition holds and always leaves a bubble after a handshake.
   always_comb begin
      issue = 1'b0;
      if (!rtn_valid && (pending != '0)) begin
         if (state == INIT) begin
            issue = 1'b1;
         end else if (state == RUN) begin
            issue = (pending >= CRD_WIDTH'(RTN_THRESH)) || timer_tc;
         end
      end
   end

   // The idle timer only runs in RUN with something pending and no offer out.
   assign timer_clr = !i_link_up || (state != RUN) || (pending == '0) || rtn_valid;

   cxl_crd_rtn_timer #(
      .RTN_TIMEOUT (RTN_TIMEOUT)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (timer_clr),
      .i_en    (1'b1),
      .o_tc    (timer_tc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         rtn_valid <= 1'b0;
         rtn_val   <= '0;
         err       <= 1'b0;
      end else if (!i_link_up) begin
         // Abort: drop everything except the sticky error.
         state     <= IDLE;
         pending   <= '0;
         rtn_valid <= 1'b0;
         rtn_val   <= '0;
      end else begin
         pending <= next_pending;
         err     <= err | overflow;

         if (handshake) begin
            rtn_valid <= 1'b0;
         end else if (issue) begin
            rtn_valid <= 1'b1;
            rtn_val   <= rtn_clamp;
         end

         case (state)
            IDLE:    state <= INIT;
            INIT:    if ((pending == '0) && !rtn_valid) state <= RUN;
            RUN:     state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   assign o_rtn_valid = rtn_valid;
   assign o_rtn_val   = rtn_val;
   assign o_pending   = pending;
   assign o_state     = state;
   assign o_err       = err;

endmodule

// File: tb/tb_cxl_crd_rtn_gen.sv
// ---------------------------------------------------------------------------
// tb_cxl_crd_rtn_gen
// Per-cycle vector tables (inputs plus expected registered outputs) for the
// credit return generator, a queue of expected return values consumed on
// every handshake, and hand-written link-down and async-reset sequences.
// ---------------------------------------------------------------------------
module tb_cxl_crd_rtn_gen;

   logic       clk;
   logic       rst_n;
   logic       link_up;
   logic       free_en;
   logic [6:0] free_val;
   logic       rtn_ready;
   logic       rtn_valid;
   logic [3:0] rtn_val;
   logic [6:0] pending;
   logic [1:0] state;
   logic       err;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic       link_up;
      logic       free_en;
      logic [6:0] free_val;
      logic       ready;
      logic       exp_valid;
      logic [3:0] exp_val;
      logic [6:0] exp_pend;
      logic [1:0] exp_state;
      logic       exp_err;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] exp_q[$];

   cxl_crd_rtn_gen dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_link_up   (link_up),
      .i_free_en   (free_en),
      .i_free_val  (free_val),
      .i_rtn_ready (rtn_ready),
      .o_rtn_valid (rtn_valid),
      .o_rtn_val   (rtn_val),
      .o_pending   (pending),
      .o_state     (state),
      .o_err       (err)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic l, input logic fe, input int fv, input logic rdy,
                      input logic ev, input int eval, input int ep, input int es,
                      input logic ee);
      vec_t v;
      v.link_up   = l;
      v.free_en   = fe;
      v.free_val  = 7'(fv);
      v.ready     = rdy;
      v.exp_valid = ev;
      v.exp_val   = 4'(eval);
      v.exp_pend  = 7'(ep);
      v.exp_state = 2'(es);
      v.exp_err   = ee;
      vecs.push_back(v);
   endtask

   // Link-up advertisement from IDLE with ready held high: 64 = 4x15 + 4.
   task automatic add_advertise(input logic e);
      add(1,0,0,1, 0, 0,64,1,e);
      add(1,0,0,1, 1,15,64,1,e);
      add(1,0,0,1, 0, 0,49,1,e);
      add(1,0,0,1, 1,15,49,1,e);
      add(1,0,0,1, 0, 0,34,1,e);
      add(1,0,0,1, 1,15,34,1,e);
      add(1,0,0,1, 0, 0,19,1,e);
      add(1,0,0,1, 1,15,19,1,e);
      add(1,0,0,1, 0, 0, 4,1,e);
      add(1,0,0,1, 1, 4, 4,1,e);
      add(1,0,0,1, 0, 0, 0,1,e);
      add(1,0,0,1, 0, 0, 0,2,e);
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd4);
   endtask

   // Apply queued vectors one cycle each, checking outputs after the edge.
   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         link_up   = vecs[i].link_up;
         free_en   = vecs[i].free_en;
         free_val  = vecs[i].free_val;
         rtn_ready = vecs[i].ready;
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d].state", tag, i), int'(state), int'(vecs[i].exp_state));
         chk($sformatf("%s[%0d].valid", tag, i), int'(rtn_valid), int'(vecs[i].exp_valid));
         chk($sformatf("%s[%0d].pending", tag, i), int'(pending), int'(vecs[i].exp_pend));
         chk($sformatf("%s[%0d].err", tag, i), int'(err), int'(vecs[i].exp_err));
         if (vecs[i].exp_valid)
            chk($sformatf("%s[%0d].val", tag, i), int'(rtn_val), int'(vecs[i].exp_val));
      end
      vecs.delete();
   endtask

   // ---------------- scoreboard: returns taken on handshake ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rtn_valid && rtn_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb.unexpected_return", int'(rtn_val), -1);
            end else begin
               chk("sb.return_val", int'(rtn_val), int'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n     = 1'b0;
      link_up   = 1'b0;
      free_en   = 1'b0;
      free_val  = '0;
      rtn_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.state", int'(state), 0);
      chk("reset.pending", int'(pending), 0);
      chk("reset.valid", int'(rtn_valid), 0);
      chk("reset.val", int'(rtn_val), 0);
      chk("reset.err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Link-up advertisement.
      add_advertise(1'b0);
      run_vecs("adv");

      // Threshold return: 5 + 5 reaches 8.
      add(1,1,5,1, 0, 0, 5,2,0);
      add(1,1,5,1, 0, 0,10,2,0);
      add(1,0,0,1, 1,10,10,2,0);
      add(1,0,0,1, 0, 0, 0,2,0);
      add(1,0,0,1, 0, 0, 0,2,0);
      exp_q.push_back(4'd10);
      run_vecs("thresh");

      // Timeout partial return of 3 credits.
      add(1,1,3,1, 0, 0, 3,2,0);
      for (int k = 1; k <= 16; k++) add(1,0,0,1, 0,0,3,2,0);
      add(1,0,0,1, 1, 3, 3,2,0);
      add(1,0,0,1, 0, 0, 0,2,0);
      exp_q.push_back(4'd3);
      run_vecs("timeout");

      // Backpressure with concurrent frees.
      add(1,1,5,0, 0, 0, 5,2,0);
      add(1,1,5,0, 0, 0,10,2,0);
      add(1,0,0,0, 1,10,10,2,0);
      add(1,1,2,0, 1,10,12,2,0);
      add(1,1,2,0, 1,10,14,2,0);
      add(1,1,2,0, 1,10,16,2,0);
      add(1,1,2,0, 1,10,18,2,0);
      add(1,1,2,1, 0, 0,10,2,0);
      add(1,0,0,1, 1,10,10,2,0);
      add(1,0,0,1, 0, 0, 0,2,0);
      exp_q.push_back(4'd10);
      exp_q.push_back(4'd10);
      run_vecs("bp");

      // Overflow, then link-down/link-up keeps the sticky error.
      add(1,1,100,0, 0, 0,100,2,0);
      add(1,1,100,0, 1,15,127,2,1);
      add(1,0,  0,0, 1,15,127,2,1);
      add(0,0,  0,0, 0, 0,  0,0,1);
      add_advertise(1'b1);
      run_vecs("ovf");

      // Link-down abort while a 15-credit offer is outstanding.
      add(0,0,0,0, 0, 0, 0,0,1);
      add(1,0,0,0, 0, 0,64,1,1);
      add(1,0,0,0, 1,15,64,1,1);
      add(0,0,0,0, 0, 0, 0,0,1);
      add_advertise(1'b1);
      run_vecs("abort");

      // Async reset mid-handshake: offer up, ready high, reset before the edge.
      add(0,0,0,0, 0, 0, 0,0,1);
      add(1,0,0,0, 0, 0,64,1,1);
      add(1,0,0,0, 1,15,64,1,1);
      run_vecs("rst_pre");
      rtn_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid.state", int'(state), 0);
      chk("rst_mid.pending", int'(pending), 0);
      chk("rst_mid.valid", int'(rtn_valid), 0);
      chk("rst_mid.val", int'(rtn_val), 0);
      chk("rst_mid.err", int'(err), 0);
      link_up   = 1'b0;
      rtn_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst.state", int'(state), 0);

      chk("sb.leftover_returns", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
